fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, in the `rclk` domain. It pops 8-bit bytes from the FIFO read port and packs `BYTES` consecutive bytes, little-endian, into one word. Each word is presented on a valid/ready output stream. It is the stage directly downstream of the FIFO and drives the FIFO's `signal_read`.

---
 rtl/fifo_rd_packer_pkg.sv | 19 +
 rtl/fifo_rd_packer_if.sv | 38 +++
 rtl/fifo_rd_packer_pack_out_reg.sv | 53 +++++
 rtl/fifo_rd_packer.sv | 136 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: byte width, FSM states
// and the width helper used for index and count fields.
package fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by fifo_rd_packer.
// master = packer side, slave = FIFO + downstream consumer side.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int unsigned BYTES = 4
);
    localparam int unsigned CW = clog2(BYTES + 1);

    logic                      empty;
    logic [BYTE_W-1:0]         read_data;
    logic                      signal_read;
    logic [BYTE_W*BYTES-1:0]   out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CW-1:0]             out_count;

    modport master (
        input  empty,
        input  read_data,
        output signal_read,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_count
    );

    modport slave (
        output empty,
        output read_data,
        input  signal_read,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_count
    );

endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Valid/ready output holding register: loads a word, drains on ready, and a
// load on the draining edge wins over the clear.
module pack_out_reg #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_count,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          free
);

    logic          valid_q, valid_d;
    logic [W-1:0]  data_q,  data_d;
    logic [CW-1:0] count_q, count_d;

    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_count = count_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs BYTES of them,
// little-endian, into words. Define PACKER_FLUSH_EN to flush idle partial words.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned BYTES        = 4,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic                  rclk,
    input  logic                  rst,
    fifo_rd_packer_if.master      bus
);

    localparam int unsigned IW = clog2(BYTES);
    localparam int unsigned CW = clog2(BYTES + 1);
    localparam int unsigned DW = BYTE_W * BYTES;
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);

    if (BYTES < 2 || BYTES > 16 || FLUSH_CYCLES < 1) begin : g_bad_param
        $error("fifo_rd_packer: BYTES must be 2..16 and FLUSH_CYCLES >= 1");
    end

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [BYTE_W-1:0] acc_q [BYTES];
    logic [BYTE_W-1:0] acc_d [BYTES];

    logic          pop;
    logic          out_free;
    logic          load;
    logic [DW-1:0] load_data;
    logic [CW-1:0] load_count;

    assign pop             = !rst && !bus.empty && (state_q == ST_FILL);
    assign bus.signal_read = pop;

`ifdef PACKER_FLUSH_EN
    localparam int unsigned FW = clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_CYCLES);

    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    // Counter saturates so a flush blocked by a busy output stays eligible.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (pop || load) begin
            flush_cnt_d = '0;
        end else if (state_q == ST_FILL && idx_q != '0 && flush_cnt_q != FLUSH_MAX) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) flush_cnt_q <= '0;
        else     flush_cnt_q <= flush_cnt_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        load       = 1'b0;
        load_count = CW'(BYTES);
        for (int unsigned k = 0; k < BYTES; k++) begin
            load_data[k*BYTE_W +: BYTE_W] = acc_q[k];
        end

        case (state_q)
            ST_FILL: begin
                if (pop) begin
                    if (idx_q == IDX_LAST) begin
                        if (out_free) begin
                            load = 1'b1;
                            load_data[DW-1 -: BYTE_W] = bus.read_data;
                            idx_d = '0;
                        end else begin
                            acc_d[IDX_LAST] = bus.read_data;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        acc_d[idx_q] = bus.read_data;
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef PACKER_FLUSH_EN
                else if (idx_q != '0 && flush_cnt_q == FLUSH_MAX && out_free) begin
                    load = 1'b1;
                    for (int unsigned k = 0; k < BYTES; k++) begin
                        if (k >= 32'(idx_q)) load_data[k*BYTE_W +: BYTE_W] = '0;
                    end
                    load_count = CW'(idx_q);
                    idx_d = '0;
                end
`endif
            end
            ST_HOLD: begin
                if (out_free) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    pack_out_reg #(
        .W  (DW),
        .CW (CW)
    ) u_out_reg (
        .clk        (rclk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .out_count  (bus.out_count),
        .free       (out_free)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (BYTES=4) with a byte-queue FIFO model
// and a negedge monitor collecting accepted words.
module tb_fifo_rd_packer;

    localparam int unsigned BYTES = 4;

    logic clk = 1'b0;
    logic rst;
    logic stall = 1'b0;

    fifo_rd_packer_if #(.BYTES(BYTES)) bus ();

    fifo_rd_packer #(
        .BYTES        (BYTES),
        .FLUSH_CYCLES (16)
    ) dut (
        .rclk (clk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  fq [$];
    logic [31:0] got_d [$];
    logic [2:0]  got_c [$];
    int          pop_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: present head byte before the edge, pop on the edge.
    initial begin : fifo_model
        logic pop_now;
        forever begin
            @(negedge clk);
            bus.empty     = (fq.size() == 0) || stall;
            bus.read_data = (fq.size() != 0) ? fq[0] : 8'h00;
            #2;
            pop_now = bus.signal_read;
            @(posedge clk);
            if (pop_now) begin
                if (fq.size() != 0) void'(fq.pop_front());
                pop_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_d.push_back(bus.out_data);
            got_c.push_back(bus.out_count);
        end
    end

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        for (int unsigned i = 0; i < n; i++) tick();
        rst = 1'b0;
        fq.delete();
        got_d.delete();
        got_c.delete();
        pop_cnt = 0;
    endtask

    initial begin : main
        logic [7:0]  bytes [$];
        logic [31:0] exp;
        int unsigned budget;

        rst           = 1'b1;
        bus.empty     = 1'b1;
        bus.read_data = 8'h00;
        bus.out_ready = 1'b0;

        // Reset with FIFO empty, held 3 edges
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sr", bus.signal_read, 0);
            check("rst_valid", bus.out_valid, 0);
        end
        check("rst_data", bus.out_data, 0);
        check("rst_count", bus.out_count, 0);
        do_reset(1);

        // Full rate, out_ready=1
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        for (int i = 0; i < 4; i++) tick();
        check("fr_pops4", pop_cnt, 4);
        check("fr_valid1", bus.out_valid, 1);
        check("fr_word1", bus.out_data, 32'h04030201);
        check("fr_count1", bus.out_count, 4);
        for (int i = 0; i < 4; i++) tick();
        check("fr_pops8", pop_cnt, 8);
        check("fr_word2", bus.out_data, 32'h08070605);
        check("fr_count2", bus.out_count, 4);
        for (int i = 0; i < 4; i++) tick();
        check("fr_stop", pop_cnt, 8);
        check("fr_nwords", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("fr_got0", got_d[0], 32'h04030201);
            check("fr_got1", got_d[1], 32'h08070605);
        end

        // Backpressure: second word waits in HOLD
        do_reset(1);
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
        for (int i = 0; i < 12; i++) tick();
        check("bp_pops", pop_cnt, 8);
        check("bp_sr_low", bus.signal_read, 0);
        check("bp_held", bus.out_data, 32'h04030201);
        check("bp_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_hold_out", bus.out_data, 32'h08070605);
        check("bp_hold_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) tick();
        check("bp_nwords", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("bp_got0", got_d[0], 32'h04030201);
            check("bp_got1", got_d[1], 32'h08070605);
        end

        // Partial word: two bytes then FIFO stays empty
        do_reset(1);
        bus.out_ready = 1'b1;
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
`ifdef PACKER_FLUSH_EN
        budget = 0;
        while (got_d.size() == 0 && budget < 60) begin
            tick();
            budget++;
        end
        check("flush_seen", got_d.size(), 1);
        if (got_d.size() != 0) begin
            check("flush_data", got_d[0], 32'h0000BBAA);
            check("flush_count", got_c[0], 2);
        end
`else
        for (int i = 0; i < 100; i++) tick();
        check("noflush_words", got_d.size(), 0);
        check("noflush_valid", bus.out_valid, 0);
`endif

        // Reset while a word is held and the accumulator is full
        do_reset(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 12; i++) tick();
        check("mr_pre_pops", pop_cnt, 8);
        check("mr_pre_valid", bus.out_valid, 1);
        do_reset(1);
        check("mr_valid", bus.out_valid, 0);
        check("mr_data", bus.out_data, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fq.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) tick();
        check("mr_nwords", got_d.size(), 1);
        if (got_d.size() != 0) begin
            check("mr_word", got_d[0], 32'h13121110);
            check("mr_count", got_c[0], 4);
        end

        // Random FIFO stalls and output backpressure
        do_reset(1);
        bytes.delete();
        for (int i = 0; i < 64; i++) begin
            bytes.push_back(8'($urandom_range(0, 255)));
            fq.push_back(bytes[i]);
        end
        budget = 0;
        while (got_d.size() < 16 && budget < 3000) begin
            stall         = ($urandom_range(0, 2) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            budget++;
        end
        stall         = 1'b0;
        bus.out_ready = 1'b1;
        check("rnd_nwords", got_d.size(), 16);
        for (int w = 0; w < 16 && w < got_d.size(); w++) begin
            for (int j = 0; j < 4; j++) exp[j*8 +: 8] = bytes[4*w + j];
            check($sformatf("rnd_word%0d", w), got_d[w], exp);
            check($sformatf("rnd_cnt%0d", w), got_c[w], 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
